// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, stall masks,
// exception codes and exception vector addresses.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IFID = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] VEC_INT = 32'h0000_0020;
  localparam logic [31:0] VEC_EXC = 32'h0000_0040;

  // Redirect target for a nonzero exception code; eret returns to EPC.
  function automatic logic [31:0] vector_for(input logic [31:0] code,
                                             input logic [31:0] epc);
    logic [31:0] vec;
    case (code)
      EXC_INT:  vec = VEC_INT;
      EXC_ERET: vec = epc;
      default:  vec = VEC_EXC;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stat.sv
// Stall watchdog with sticky timeout flag, plus saturating stall-cycle and
// wrapping flush performance counters.
module pipe_ctrl_stat #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active_i,
  input  logic        flush_i,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  localparam logic [16:0] LIMIT = 17'(STALL_LIMIT);

  logic [15:0] wd_q, wd_d;
  logic        to_q, to_d;
  logic [31:0] sc_q, sc_d;
  logic [15:0] fc_q, fc_d;
  logic [16:0] wd_inc;

  always_comb begin
    wd_inc = {1'b0, wd_q} + 17'd1;
    wd_d   = wd_q;
    to_d   = to_q;
    sc_d   = sc_q;
    fc_d   = fc_q;
    if (flush_i || !stall_active_i) begin
      wd_d = 16'd0;
    end else if (wd_q != 16'hffff) begin
      wd_d = wd_inc[15:0];
    end
    // The flag rises on the edge closing the stall cycle that reaches the limit.
    if (flush_i) begin
      to_d = 1'b0;
    end else if (stall_active_i && wd_inc >= LIMIT) begin
      to_d = 1'b1;
    end
    if (stall_active_i && sc_q != 32'hffff_ffff) begin
      sc_d = sc_q + 32'd1;
    end
    if (flush_i) begin
      fc_d = fc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= 16'd0;
      to_q <= 1'b0;
      sc_q <= 32'd0;
      fc_q <= 16'd0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
      sc_q <= sc_d;
      fc_q <= fc_d;
    end
  end

  assign stall_timeout_o = to_q;
  assign stall_cycles_o  = sc_q;
  assign flush_count_o   = fc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall, flush and redirect.
// state   | meaning
// S_RUN   | pipeline advancing normally
// S_STALL | at least one stage held this cycle
// S_FLUSH | flush cycle just taken; if/id requests and exceptions masked
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  state_e      state_q, state_d;
  logic        in_flush;
  logic        if_req, id_req;
  logic [31:0] exc_m;

  always_comb begin
    in_flush = (state_q == S_FLUSH);
    if_req   = stallreq_from_if & ~in_flush;
    id_req   = stallreq_from_id & ~in_flush;
    exc_m    = in_flush ? EXC_NONE : excepttype_i;
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = 32'd0;
    // A pending exception waits behind a mem stall and is taken once mem releases.
    if (!rst) begin
      if (exc_m != EXC_NONE && !stallreq_from_mem) begin
        flush  = 1'b1;
        new_pc = vector_for(exc_m, cp0_epc_i);
      end else if (stallreq_from_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_from_ex) begin
        stall = STALL_EX;
      end else if (id_req || if_req) begin
        stall = STALL_IFID;
      end
    end
    if (flush) begin
      state_d = S_FLUSH;
    end else if (stall != STALL_NONE) begin
      state_d = S_STALL;
    end else begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_ctrl_stat #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stat (
    .clk            (clk),
    .rst            (rst),
    .stall_active_i (stall != STALL_NONE),
    .flush_i        (flush),
    .stall_timeout_o(stall_timeout_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table for the combinational
// outputs plus hand sequences for multi-cycle stall/flush/watchdog cases.
module tb_pipe_ctrl;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        to;
  logic [31:0] sc;
  logic [15:0] fc;

  pipe_ctrl #(.STALL_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (s_if),
    .stallreq_from_id (s_id),
    .stallreq_from_ex (s_ex),
    .stallreq_from_mem(s_mem),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout_o  (to),
    .stall_cycles_o   (sc),
    .flush_count_o    (fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    string       name;
  } exp_t;

  typedef struct {
    logic        fi, fd, fe, fm;
    logic [31:0] exc, epc;
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    string       name;
  } vec_t;

  exp_t q[$];
  int tests = 0;
  int failed = 0;

  // Bench-side model of the status counters.
  int unsigned m_wd = 0;
  logic        m_to = 1'b0;
  logic [31:0] m_sc = 32'd0;
  logic [15:0] m_fc = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Drive one cycle, score it at negedge, return at posedge+1.
  task automatic step(input logic r, input logic fi, input logic fd, input logic fe,
                      input logic fm, input logic [31:0] e, input logic [31:0] p,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input string name);
    exp_t x;
    rst = r; s_if = fi; s_id = fd; s_ex = fe; s_mem = fm; exc = e; epc = p;
    x.stall = es; x.flush = ef; x.pc = ep; x.name = name;
    q.push_back(x);
    if (r) begin
      m_wd = 0; m_to = 1'b0; m_sc = 32'd0; m_fc = 16'd0;
    end else begin
      if (ef || es == 6'd0) begin
        m_wd = 0;
        if (ef) m_to = 1'b0;
      end else begin
        if (m_wd + 1 >= LIMIT) m_to = 1'b1;
        if (m_wd != 65535) m_wd++;
      end
      if (es != 6'd0 && m_sc != 32'hffff_ffff) m_sc++;
      if (ef) m_fc++;
    end
    @(negedge clk);
    if (q.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_empty %s: got 0 entries want 1", name);
    end else begin
      x = q.pop_front();
      chk({x.name, ".stall"}, {26'd0, stall}, {26'd0, x.stall});
      chk({x.name, ".flush"}, {31'd0, flush}, {31'd0, x.flush});
      chk({x.name, ".new_pc"}, new_pc, x.pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    step(0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, name);
  endtask

  task automatic do_rst();
    step(1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, "rst");
  endtask

  task automatic chk_stat(input string name);
    chk({name, ".timeout"}, {31'd0, to}, {31'd0, m_to});
    chk({name, ".stall_cycles"}, sc, m_sc);
    chk({name, ".flush_count"}, {16'd0, fc}, {16'd0, m_fc});
  endtask

  vec_t vt[14];

  initial begin
    rst = 1'b1; s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; exc = 0; epc = 0;
    vt[0]  = '{0,0,0,0, 32'h0,  32'h0,        6'b000000, 0, 32'h0,         "v_none"};
    vt[1]  = '{1,0,0,0, 32'h0,  32'h0,        6'b000111, 0, 32'h0,         "v_if"};
    vt[2]  = '{0,1,0,0, 32'h0,  32'h0,        6'b000111, 0, 32'h0,         "v_id"};
    vt[3]  = '{0,0,1,0, 32'h0,  32'h0,        6'b001111, 0, 32'h0,         "v_ex"};
    vt[4]  = '{0,0,0,1, 32'h0,  32'h0,        6'b011111, 0, 32'h0,         "v_mem"};
    vt[5]  = '{0,1,0,1, 32'h0,  32'h0,        6'b011111, 0, 32'h0,         "v_mem_id"};
    vt[6]  = '{1,0,1,0, 32'h0,  32'h0,        6'b001111, 0, 32'h0,         "v_ex_if"};
    vt[7]  = '{0,0,0,0, 32'h1,  32'h0,        6'b000000, 1, 32'h20,        "v_exc1"};
    vt[8]  = '{0,1,0,0, 32'h8,  32'h0,        6'b000000, 1, 32'h40,        "v_exc8_id"};
    vt[9]  = '{0,0,0,0, 32'ha,  32'h0,        6'b000000, 1, 32'h40,        "v_exca"};
    vt[10] = '{0,0,0,0, 32'he,  32'hdeadbeef, 6'b000000, 1, 32'hdeadbeef,  "v_eret"};
    vt[11] = '{0,0,0,0, 32'h5,  32'h0,        6'b000000, 1, 32'h40,        "v_exc5"};
    vt[12] = '{0,0,0,1, 32'he,  32'h1234,     6'b011111, 0, 32'h0,         "v_eret_mem"};
    vt[13] = '{0,0,1,0, 32'hc,  32'h0,        6'b000000, 1, 32'h40,        "v_excc_ex"};

    @(posedge clk); #1;
    // Reset overrides active requests.
    step(1, 1, 1, 1, 1, 32'h8, 32'h99, 6'd0, 0, 0, "rst_override");
    chk_stat("reset");

    for (int i = 0; i < 14; i++) begin
      step(0, vt[i].fi, vt[i].fd, vt[i].fe, vt[i].fm, vt[i].exc, vt[i].epc,
           vt[i].es, vt[i].ef, vt[i].ep, vt[i].name);
      idle({vt[i].name, "_idle"});
    end
    chk_stat("table");

    // Three-cycle EX stall.
    do_rst();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, "ex3");
    chk("ex3.stall_cycles", sc, 32'd3);
    chk("ex3.timeout_below", {31'd0, to}, 32'd0);
    idle("ex3_release");
    chk_stat("ex3");

    // Watchdog at limit, sticky, cleared by flush; flush cycle masks if/id/exc.
    do_rst();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, "wd");
    chk("wd.before_limit", {31'd0, to}, 32'd0);
    step(0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, "wd4");
    chk("wd.at_limit", {31'd0, to}, 32'd1);
    idle("wd_hold1");
    idle("wd_hold2");
    chk("wd.sticky", {31'd0, to}, 32'd1);
    step(0, 0, 0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h40, "flush8");
    chk("flush8.timeout_clr", {31'd0, to}, 32'd0);
    chk("flush8.count", {16'd0, fc}, 32'd1);
    step(0, 0, 1, 0, 0, 32'h8, 0, 6'd0, 0, 0, "masked_id");
    step(0, 0, 0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h40, "flush8b");
    step(0, 0, 1, 1, 0, 32'h8, 0, 6'b001111, 0, 0, "flush_ex_honoured");
    idle("wd_end");
    chk_stat("wd");

    // Eret held behind a mem stall, taken when mem releases.
    do_rst();
    step(0, 0, 0, 0, 1, 32'he, 32'h1234, 6'b011111, 0, 0, "eret_mem1");
    step(0, 0, 0, 0, 1, 32'he, 32'h1234, 6'b011111, 0, 0, "eret_mem2");
    step(0, 0, 0, 0, 0, 32'he, 32'h1234, 6'd0, 1, 32'h1234, "eret_take");
    idle("eret_end");
    chk_stat("eret");

    // Reset mid-stall.
    do_rst();
    step(0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, "pre_rst1");
    step(0, 0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, "pre_rst2");
    step(1, 0, 0, 1, 0, 32'h8, 0, 6'd0, 0, 0, "rst_mid_stall");
    chk("rst_mid.stall_cycles", sc, 32'd0);
    chk_stat("rst_mid");
    idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: parameter STALL_LIMIT, default 255, stall-cycle count at which the watchdog fires (range 1..65535).
REQ-002 SHALL: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL: stallreq_from_if  input  1  fetch bus wait.
REQ-005 SHALL: stallreq_from_id  input  1  load-use hazard.
REQ-006 SHALL: stallreq_from_ex  input  1  multi-cycle EX op (div/madd) busy.
REQ-007 SHALL: stallreq_from_mem  input  1  data bus wait.
REQ-008 SHALL: excepttype_i  input  32  final exception code from MEM; 0 = none.
REQ-009 SHALL: cp0_epc_i  input  32  EPC value for eret.
REQ-010 SHALL: stall  output  6  per-stage hold; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
REQ-011 SHALL: flush  output  1  clear all pipeline registers this cycle.
REQ-012 SHALL: new_pc  output  32  redirect target, valid while flush=1, else 0.
REQ-013 SHALL: stall_timeout_o  output  1  sticky watchdog flag.
REQ-014 SHALL: stall_cycles_o  output  32  saturating count of cycles with stall!=0.
REQ-015 SHALL: flush_count_o  output  16  wrapping count of flushes.

Function
REQ-016 SHALL: stall, flush and new_pc are combinational from inputs and current FSM state (zero-cycle latency); status outputs are registered.
REQ-017 SHALL: stall priority, highest first: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000111; none -> 6'b000000.
REQ-018 SHALL: flush=1 when excepttype_i!=0, stallreq_from_mem=0 and state!=S_FLUSH; while flush=1, stall=0.
REQ-019 SHALL: when excepttype_i!=0 and stallreq_from_mem=1, no flush occurs; the mem stall applies and the flush is taken on the first cycle mem releases.
REQ-020 SHALL: new_pc mapping: 0x1 -> 0x00000020; 0x8, 0xa, 0xc, 0xd -> 0x00000040; 0xe -> cp0_epc_i; any other nonzero code -> 0x00000040.
REQ-021 SHALL: FSM states S_RUN, S_STALL, S_FLUSH; reset state S_RUN.
REQ-022 SHALL: S_RUN: flush -> S_FLUSH; else stall!=0 -> S_STALL; else stay.
REQ-023 SHALL: S_STALL: flush -> S_FLUSH; else stall==0 -> S_RUN; else stay.
REQ-024 SHALL: S_FLUSH lasts exactly one cycle; stallreq_from_if, stallreq_from_id and excepttype_i are masked; ex/mem requests are honoured; next state per the S_RUN rules.
REQ-025 SHALL: 16-bit watchdog counter increments each cycle stall!=0, clears when stall==0 or flush=1, and saturates.
REQ-026 SHALL: when the watchdog counter reaches STALL_LIMIT, stall_timeout_o sets on the next edge and stays 1 until rst or a flush.
REQ-027 SHALL: stall_cycles_o increments each cycle stall!=0 and holds at 0xFFFFFFFF.
REQ-028 SHALL: flush_count_o increments by 1 per flush cycle and wraps from 0xFFFF to 0.

Reset
REQ-029 SHALL: on rst, state=S_RUN, watchdog=0, stall_timeout_o=0, stall_cycles_o=0, flush_count_o=0; stall=0, flush=0 and new_pc=0 while rst=1, regardless of other inputs.
REQ-030 SHALL: rst asserted mid-stall or mid-flush overrides all inputs on that edge.

Structure
REQ-031 SHALL: stall encodings, exception codes, vector addresses and FSM state encodings live in define.v beside the existing Stop/NoStop and Flush macros.
REQ-032 SHALL: the watchdog plus the two perf counters form one natural sub-module, pipe_ctrl_stat; everything else stays flat.

Verification
REQ-033 SHALL: stallreq_from_ex=1 for 3 cycles -> stall=6'b001111 for 3 cycles, stall_cycles_o=3, state returns to S_RUN.
REQ-034 SHALL: excepttype_i=0x8 -> flush=1, new_pc=0x40, stall=0; next cycle stallreq_from_id=1 is ignored; flush_count_o=1.
REQ-035 SHALL: excepttype_i=0xe with cp0_epc_i=0x00001234 while stallreq_from_mem=1 for 2 cycles -> stall=6'b011111 for 2 cycles, then flush=1 with new_pc=0x00001234.
REQ-036 SHALL: stallreq_from_mem and stallreq_from_id both 1 -> stall=6'b011111.
REQ-037 SHALL: STALL_LIMIT=4 with stallreq_from_ex held -> stall_timeout_o=1 after the 4th stall cycle, cleared by the next flush.
REQ-038 SHALL: rst pulsed during S_STALL -> all counters 0, stall=0, state S_RUN.
